// File: rtl/pc_sequencer_if.sv
// Fetch channel between the PC sequencer (master) and instruction memory (slave).
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_WIDTH-1:0] ifu_req_addr;
    logic                  ifu_rsp_valid;
    logic [31:0]           ifu_rsp_data;

    modport master (
        output ifu_req_valid,
        output ifu_req_addr,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rsp_data
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_req_addr,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rsp_data
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/exec/retire sequencer owning the architectural PC.
// Define PC_SEQ_FTRACE_EN to add function-call tracing at retire.
module pc_sequencer #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC      = ADDR_WIDTH'(32'h8000_0000),
    parameter int                    FETCH_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_sequencer_if.master        ifu,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    input  logic [1:0]            jump_flag,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic                  mem_op,
    input  logic                  lsu_done,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  retire,
    output logic [31:0]           instret,
    output logic                  halted,
    output logic                  fault,
    output logic [1:0]            fault_cause
);
    localparam int            TW       = $clog2(FETCH_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(FETCH_TIMEOUT - 1);
    localparam logic [1:0]    C_TMO    = 2'b01;
    localparam logic [1:0]    C_ALIGN  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_EXEC,
        S_MEM_WAIT,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [TW-1:0]         tcnt;
    logic [ADDR_WIDTH-1:0] tgt_q;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] commit_pc;
    logic [ADDR_WIDTH-1:0] off_a;
    logic [ADDR_WIDTH-1:0] src_a;
    logic                  tmo_hit;
    logic                  misaligned;
    logic                  commit;
    logic                  fault_set;
    logic [1:0]            cause_n;

    assign off_a = ADDR_WIDTH'(offset);
    assign src_a = ADDR_WIDTH'(src1);

    always_comb begin
        target = pc + ADDR_WIDTH'(4);
        unique case (1'b1)
            jump_flag[1]:          target = pc + ADDR_WIDTH'(4);
            (jump_flag == 2'b01):  target = (src_a + off_a) & ~ADDR_WIDTH'(1);
            (jump_flag == 2'b00):  target = pc + off_a;
            default:               target = pc + ADDR_WIDTH'(4);
        endcase
    end

    assign misaligned = ~jump_flag[1] & target[1];
    assign tmo_hit    = (tcnt == TMO_LAST);

    // A response arriving in the last allowed cycle beats the timeout.
    always_comb begin
        state_n   = state;
        commit    = 1'b0;
        commit_pc = target;
        fault_set = 1'b0;
        cause_n   = C_TMO;
        unique case (state)
            S_FETCH_REQ: begin
                if (tmo_hit) begin
                    state_n   = S_FAULT;
                    fault_set = 1'b1;
                end else if (ifu.ifu_req_ready) begin
                    state_n = S_FETCH_WAIT;
                end
            end
            S_FETCH_WAIT: begin
                if (ifu.ifu_rsp_valid) begin
                    state_n = S_EXEC;
                end else if (tmo_hit) begin
                    state_n   = S_FAULT;
                    fault_set = 1'b1;
                end
            end
            S_EXEC: begin
                if (halt) begin
                    state_n = S_HALTED;
                end else if (misaligned) begin
                    state_n   = S_FAULT;
                    fault_set = 1'b1;
                    cause_n   = C_ALIGN;
                end else if (mem_op && !lsu_done) begin
                    state_n = S_MEM_WAIT;
                end else begin
                    commit  = 1'b1;
                    state_n = S_FETCH_REQ;
                end
            end
            S_MEM_WAIT: begin
                if (lsu_done) begin
                    commit    = 1'b1;
                    commit_pc = tgt_q;
                    state_n   = S_FETCH_REQ;
                end
            end
            default: begin
                state_n = state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH_REQ;
            pc          <= RESET_PC;
            tcnt        <= '0;
            tgt_q       <= '0;
            inst        <= '0;
            retire      <= 1'b0;
            instret     <= '0;
            fault_cause <= 2'b00;
        end else begin
            state  <= state_n;
            retire <= commit;
            if (commit) begin
                pc      <= commit_pc;
                instret <= instret + 32'd1;
            end
            if (state == S_EXEC) begin
                tgt_q <= target;
            end
            if (state == S_FETCH_WAIT && ifu.ifu_rsp_valid) begin
                inst <= ifu.ifu_rsp_data;
            end
            if (fault_set) begin
                fault_cause <= cause_n;
            end
            if (state_n == S_FETCH_REQ && state != S_FETCH_REQ) begin
                tcnt <= '0;
            end else if (state == S_FETCH_REQ || state == S_FETCH_WAIT) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign ifu.ifu_req_valid = (state == S_FETCH_REQ);
    assign ifu.ifu_req_addr  = pc;
    assign inst_valid        = (state == S_EXEC);
    assign halted            = (state == S_HALTED);
    assign fault             = (state == S_FAULT);

`ifdef PC_SEQ_FTRACE_EN
    function automatic void trace_func_call(input int call_pc, input int call_tgt);
        $display("ftrace call %h -> %h", call_pc, call_tgt);
    endfunction

    function automatic void trace_func_ret(input int ret_pc);
        $display("ftrace ret %h", ret_pc);
    endfunction

    logic [1:0] jf_q;
    logic [1:0] jf_cur;

    // Memory-op jumps trace at retire, so the jump class is held across MEM_WAIT.
    assign jf_cur = (state == S_EXEC) ? jump_flag : jf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            jf_q <= 2'b10;
        end else if (state == S_EXEC) begin
            jf_q <= jump_flag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && !jf_cur[1]) begin
            if (jf_cur[0] && inst == 32'h0000_8067) begin
                trace_func_ret(int'(pc));
            end else begin
                trace_func_call(int'(pc), int'(commit_pc));
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table, multi-cycle corner sequences,
// and a randomized instruction stream against a transaction-level model.
module tb_pc_sequencer;
    localparam int          TMO    = 12;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [1:0]  jf;
        logic [31:0] off;
        logic [31:0] s1;
        logic        mem;
        logic [31:0] exp_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic [1:0]  jump_flag;
    logic [31:0] offset;
    logic [31:0] src1;
    logic        mem_op;
    logic        lsu_done;
    logic        halt;
    logic [31:0] pc;
    logic        retire;
    logic [31:0] instret;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    bit          noise;
    vec_t        tbl[12];

    pc_sequencer_if #(.ADDR_WIDTH(32)) bus ();

    pc_sequencer #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .RESET_PC     (RST_PC),
        .FETCH_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ifu        (bus),
        .inst       (inst),
        .inst_valid (inst_valid),
        .jump_flag  (jump_flag),
        .offset     (offset),
        .src1       (src1),
        .mem_op     (mem_op),
        .lsu_done   (lsu_done),
        .halt       (halt),
        .pc         (pc),
        .retire     (retire),
        .instret    (instret),
        .halted     (halted),
        .fault      (fault),
        .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_target(input logic [1:0] jf, input logic [31:0] p,
                                               input logic [31:0] off, input logic [31:0] s1);
        if (jf[1]) return p + 32'd4;
        if (jf[0]) return (s1 + off) & 32'hFFFF_FFFE;
        return p + off;
    endfunction

    task automatic idle_inputs();
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        bus.ifu_rsp_data  = 32'h0;
        jump_flag = 2'b10;
        offset    = 32'h0;
        src1      = 32'h0;
        mem_op    = 1'b0;
        lsu_done  = 1'b0;
        halt      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_pc      = RST_PC;
        m_instret = 32'h0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_req_valid"}, bus.ifu_req_valid, 1);
        chk({tag, "_addr"}, bus.ifu_req_addr, RST_PC);
        chk({tag, "_instret"}, instret, 0);
        chk({tag, "_retire"}, retire, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_cause"}, fault_cause, 0);
        chk({tag, "_inst_valid"}, inst_valid, 0);
        chk({tag, "_inst"}, inst, 0);
    endtask

    // Ready after r stall cycles, response on the d-th wait cycle.
    task automatic fetch(input int r, input int d, input logic [31:0] data);
        chk("req_valid", bus.ifu_req_valid, 1);
        chk("req_addr", bus.ifu_req_addr, m_pc);
        for (int i = 0; i < r; i++) begin
            bus.ifu_req_ready = 1'b0;
            bus.ifu_rsp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.ifu_rsp_data  = 32'hDEAD_BEEF;
            lsu_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            chk("addr_stable", bus.ifu_req_addr, m_pc);
            chk("req_hold", bus.ifu_req_valid, 1);
        end
        bus.ifu_req_ready = 1'b1;
        bus.ifu_rsp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.ifu_rsp_data  = 32'hDEAD_BEEF;
        tick();
        bus.ifu_req_ready = 1'b0;
        bus.ifu_rsp_valid = 1'b0;
        chk("wait_req_low", bus.ifu_req_valid, 0);
        chk("retire_pulse", retire, 0);
        for (int i = 1; i < d; i++) begin
            lsu_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            chk("wait_no_exec", inst_valid, 0);
            chk("wait_no_fault", fault, 0);
        end
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_data  = data;
        lsu_done = 1'b0;
        tick();
        bus.ifu_rsp_valid = 1'b0;
        chk("exec_valid", inst_valid, 1);
        chk("exec_inst", inst, data);
    endtask

    // lsu_done arrives ld cycles after EXEC (0 = same cycle).
    task automatic exec(input logic [1:0] jf, input logic [31:0] off, input logic [31:0] s1,
                        input logic mem, input int ld, input logic [31:0] exp_pc);
        jump_flag = jf;
        offset    = off;
        src1      = s1;
        mem_op    = mem;
        lsu_done  = mem && (ld == 0);
        tick();
        lsu_done = 1'b0;
        mem_op   = 1'b0;
        if (mem && ld > 0) begin
            chk("memwait_retire", retire, 0);
            chk("memwait_pc", pc, m_pc);
            chk("memwait_iv", inst_valid, 0);
            for (int i = 1; i < ld; i++) begin
                jump_flag = 2'($urandom);
                offset    = $urandom;
                src1      = $urandom;
                halt      = 1'($urandom);
                tick();
                chk("memwait_hold", retire, 0);
            end
            halt     = 1'b0;
            lsu_done = 1'b1;
            tick();
            lsu_done = 1'b0;
        end
        m_pc      = exp_pc;
        m_instret = m_instret + 32'd1;
        chk("commit_retire", retire, 1);
        chk("commit_pc", pc, m_pc);
        chk("commit_instret", instret, m_instret);
        chk("commit_next_req", bus.ifu_req_valid, 1);
    endtask

    initial begin
        logic [1:0]  jf;
        logic [31:0] off;
        logic [31:0] s1;
        logic        mem;
        int          ld;
        int          k;

        tbl[0]  = '{2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h8000_0004};
        tbl[1]  = '{2'b11, 32'h1234_5678, 32'h0000_0000, 1'b0, 32'h8000_0008};
        tbl[2]  = '{2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h8000_000C};
        tbl[3]  = '{2'b00, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'h8000_001C};
        tbl[4]  = '{2'b00, 32'hFFFF_FFF8, 32'h0000_0000, 1'b0, 32'h8000_0014};
        tbl[5]  = '{2'b01, 32'h0000_0003, 32'h8000_0101, 1'b0, 32'h8000_0104};
        tbl[6]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_1001, 1'b0, 32'h0000_1000};
        tbl[7]  = '{2'b00, 32'h7FFF_F000, 32'h0000_0000, 1'b0, 32'h8000_0000};
        tbl[8]  = '{2'b10, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h8000_0004};
        tbl[9]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFC};
        tbl[10] = '{2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tbl[11] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};

        noise = 1'b0;
        do_reset();
        chk_reset_state("reset");

        for (int i = 0; i < 12; i++) begin
            fetch(0, 1, 32'h0000_0013 + 32'(i));
            exec(tbl[i].jf, tbl[i].off, tbl[i].s1, tbl[i].mem, 0, tbl[i].exp_pc);
        end

        // jal then a jalr landing on a half-word target
        do_reset();
        fetch(0, 1, 32'h0100_006F);
        exec(2'b00, 32'h10, 32'h0, 1'b0, 0, 32'h8000_0010);
        fetch(0, 1, 32'h0010_8067);
        jump_flag = 2'b01;
        src1      = 32'h8000_0101;
        offset    = 32'h1;
        tick();
        chk("misalign_fault", fault, 1);
        chk("misalign_cause", fault_cause, 2'b10);
        chk("misalign_pc", pc, 32'h8000_0010);
        chk("misalign_retire", retire, 0);
        chk("misalign_instret", instret, 1);
        chk("misalign_req", bus.ifu_req_valid, 0);
        bus.ifu_req_ready = 1'b1;
        bus.ifu_rsp_valid = 1'b1;
        lsu_done = 1'b1;
        tick();
        tick();
        chk("fault_sticky", fault, 1);
        chk("fault_pc_held", pc, 32'h8000_0010);
        chk("fault_iv", inst_valid, 0);
        chk("fault_req", bus.ifu_req_valid, 0);

        // halt outranks a misaligned target and a memory op
        do_reset();
        fetch(0, 1, 32'h0010_0073);
        jump_flag = 2'b01;
        src1      = 32'h8000_0002;
        offset    = 32'h0;
        mem_op    = 1'b1;
        halt      = 1'b1;
        tick();
        idle_inputs();
        chk("halt_halted", halted, 1);
        chk("halt_fault", fault, 0);
        chk("halt_retire", retire, 0);
        chk("halt_pc", pc, RST_PC);
        chk("halt_instret", instret, 0);
        tick();
        tick();
        chk("halt_sticky", halted, 1);
        chk("halt_req", bus.ifu_req_valid, 0);
        chk("halt_iv", inst_valid, 0);

        // long stalls below the timeout, then a late lsu_done
        do_reset();
        fetch(5, 4, 32'h0000_2003);
        exec(2'b10, 32'h0, 32'h0, 1'b1, 6, RST_PC + 32'd4);
        fetch(5, 6, 32'h0000_0013);
        exec(2'b10, 32'h0, 32'h0, 1'b0, 0, RST_PC + 32'd8);

        // timeout while waiting for a response
        do_reset();
        bus.ifu_req_ready = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        for (int i = 0; i < TMO - 2; i++) tick();
        chk("tmo_wait_nofault", fault, 0);
        tick();
        chk("tmo_wait_fault", fault, 1);
        chk("tmo_wait_cause", fault_cause, 2'b01);
        chk("tmo_wait_req", bus.ifu_req_valid, 0);
        chk("tmo_wait_pc", pc, RST_PC);

        // timeout with the request never accepted
        do_reset();
        for (int i = 0; i < TMO - 1; i++) tick();
        chk("tmo_req_nofault", fault, 0);
        chk("tmo_req_valid", bus.ifu_req_valid, 1);
        tick();
        chk("tmo_req_fault", fault, 1);
        chk("tmo_req_cause", fault_cause, 2'b01);
        chk("tmo_req_low", bus.ifu_req_valid, 0);

        do_reset();
        chk_reset_state("restart");
        fetch(0, 1, 32'h0000_0013);
        exec(2'b10, 32'h0, 32'h0, 1'b0, 0, RST_PC + 32'd4);

        // reset while parked in a memory wait
        fetch(0, 1, 32'h0000_2003);
        jump_flag = 2'b00;
        offset    = 32'h40;
        mem_op    = 1'b1;
        tick();
        mem_op = 1'b0;
        chk("midrst_memwait", inst_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        m_pc      = RST_PC;
        m_instret = 32'h0;
        chk_reset_state("midrst");

        // randomized instruction stream
        do_reset();
        noise = 1'b1;
        for (int n = 0; n < 200; n++) begin
            k   = $urandom_range(0, 2);
            off = $urandom & 32'hFFFF_FFFC;
            s1  = $urandom & 32'hFFFF_FFFD;
            jf  = (k == 0) ? {1'b1, 1'($urandom)} : ((k == 1) ? 2'b00 : 2'b01);
            mem = ($urandom_range(0, 3) == 0);
            ld  = mem ? $urandom_range(0, 5) : 0;
            fetch($urandom_range(0, 4), $urandom_range(1, 6), $urandom);
            exec(jf, off, s1, mem, ld, ref_target(jf, m_pc, off, s1));
        end
        noise = 1'b0;
        chk("rand_no_fault", fault, 0);
        chk("rand_no_halt", halted, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
